// File: rtl/uart_cmd_packer.sv
// Queues whole commands and serialises each one MSB-first as DATA_WIDTH-bit bytes with an optional checksum byte.
// The first strobe comes two edges after a push into an idle block. Each following byte is strobed one edge after tx_done. cmd_ready drops only when the FIFO is full.
module uart_cmd_packer #(
  parameter int DATA_WIDTH  = 8,
  parameter int CMD_PKT_LEN = 16,
  parameter int FIFO_DEPTH  = 4,
  parameter int CHECKSUM_EN = 0
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [CMD_PKT_LEN-1:0]             cmd,
  input  logic                               cmd_valid,
  output logic                               cmd_ready,
  output logic [DATA_WIDTH-1:0]              tx_data,
  output logic                               tx_en,
  input  logic                               tx_done,
  output logic                               busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_level
);

  localparam int NUM_BYTES = CMD_PKT_LEN / DATA_WIDTH;
  localparam int PTR_W     = $clog2(FIFO_DEPTH);
  localparam int LVL_W     = $clog2(FIFO_DEPTH+1);
  localparam int CNT_W     = $clog2(NUM_BYTES+1);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_WAIT} state_t;

  logic [CMD_PKT_LEN-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]       r_wr_ptr, r_rd_ptr;
  logic [LVL_W-1:0]       r_level;

  state_t                 r_state;
  logic [CMD_PKT_LEN-1:0] r_shift;
  logic [CNT_W-1:0]       r_payload_left;
  logic                   r_csum_pend;
  logic [DATA_WIDTH-1:0]  r_csum;
  logic [DATA_WIDTH-1:0]  r_tx_data;
  logic                   r_tx_en;

  logic                   w_full, w_empty, w_push, w_pop;
  logic [CMD_PKT_LEN-1:0] w_head;
  logic [DATA_WIDTH-1:0]  w_head_top, w_next_byte;

  assign w_full      = (r_level == LVL_W'(FIFO_DEPTH));
  assign w_empty     = (r_level == '0);
  // Readiness depends only on full, so a pop on the same edge never admits a push into a full FIFO.
  assign w_push      = cmd_valid && !w_full;
  assign w_pop       = (r_state == S_IDLE) && !w_empty;
  assign w_head      = r_mem[r_rd_ptr];
  assign w_head_top  = w_head[CMD_PKT_LEN-1 -: DATA_WIDTH];
  assign w_next_byte = r_shift[CMD_PKT_LEN-1 -: DATA_WIDTH];

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= cmd;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LVL_W'(1);
        2'b01:   r_level <= r_level - LVL_W'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_shift        <= '0;
      r_payload_left <= '0;
      r_csum_pend    <= 1'b0;
      r_csum         <= '0;
      r_tx_data      <= '0;
      r_tx_en        <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (!w_empty) begin
            r_shift        <= w_head << DATA_WIDTH;
            r_tx_data      <= w_head_top;
            r_tx_en        <= 1'b1;
            r_csum         <= w_head_top;
            // Reads drop the trailing data byte.
            r_payload_left <= w_head[CMD_PKT_LEN-1] ? CNT_W'(NUM_BYTES-1) : CNT_W'(NUM_BYTES-2);
            r_csum_pend    <= (CHECKSUM_EN != 0);
            r_state        <= S_SEND;
          end
        end
        S_SEND: begin
          r_tx_en <= 1'b0;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (tx_done) begin
            if (r_payload_left != '0) begin
              r_tx_data      <= w_next_byte;
              r_shift        <= r_shift << DATA_WIDTH;
              r_csum         <= r_csum + w_next_byte;
              r_payload_left <= r_payload_left - CNT_W'(1);
              r_tx_en        <= 1'b1;
              r_state        <= S_SEND;
            end else if (r_csum_pend) begin
              r_tx_data   <= r_csum;
              r_csum_pend <= 1'b0;
              r_tx_en     <= 1'b1;
              r_state     <= S_SEND;
            end else begin
              r_state <= S_IDLE;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign cmd_ready  = !w_full;
  assign tx_data    = r_tx_data;
  assign tx_en      = r_tx_en;
  assign busy       = (r_state != S_IDLE);
  assign fifo_level = r_level;

endmodule

// File: doc/uart_cmd_packer.md
# uart_cmd_packer

Parametrised command-to-byte packetizer between the host command interface and the byte-level UART transmitter. It buffers whole commands in a small FIFO and splits each one into DATA_WIDTH-bit bytes, most significant byte first. Each byte is handed to the transmitter with a one-cycle tx_en strobe and the block waits for tx_done before the next byte. Beyond the single-command interface generation it adds command queuing, arbitrary packet length, read/write-dependent byte count and an optional checksum byte.

## Interface
- DATA_WIDTH, 8, bits per transmitted byte
- CMD_PKT_LEN, 16, command width; integer multiple of DATA_WIDTH, ≥ 2·DATA_WIDTH; NUM_BYTES = CMD_PKT_LEN/DATA_WIDTH
- FIFO_DEPTH, 4, command FIFO entries; power of two, ≥ 2
- CHECKSUM_EN, 0, 1 = append a checksum byte to every packet
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- cmd  in  CMD_PKT_LEN  command; [CMD_PKT_LEN-1] = R/W (0 read, 1 write); lowest byte = write data
- cmd_valid  in  1  command offered
- cmd_ready  out  1  FIFO can accept; equals !full
- tx_data  out  DATA_WIDTH  byte to transmit, registered
- tx_en  out  1  one-cycle transmit strobe, registered
- tx_done  in  1  transmitter finished current byte (single-cycle pulse)
- busy  out  1  high whenever the FSM is not IDLE
- fifo_level  out  $clog2(FIFO_DEPTH+1)  commands currently queued

## Operation
- Push on the clk edge where cmd_valid && cmd_ready. A push is refused when the FIFO is full, even if a pop happens on the same edge.
- Byte count per packet:
  - Write: NUM_BYTES bytes.
  - Read: NUM_BYTES-1 bytes; the lowest (data) byte is omitted.
  - Plus one checksum byte if CHECKSUM_EN.
- Checksum = sum of all preceding bytes of the packet, mod 2^DATA_WIDTH.
- FSM states: IDLE, SEND, WAIT.
  - IDLE: if the FIFO is not empty, pop the head into the shift register, load the byte counter, and drive tx_data = top byte, tx_en = 1. Go to SEND.
  - SEND (one cycle): tx_en <= 0. Go to WAIT.
  - WAIT on tx_done with bytes remaining: shift, tx_data <= next byte (or the checksum after the last payload byte), tx_en <= 1. Go to SEND.
  - WAIT on tx_done with none remaining: go to IDLE.
  - WAIT without tx_done: stay in WAIT.
- tx_done is sampled only in WAIT; in IDLE or SEND it is ignored.
- tx_data holds its last value between strobes.

## Timing
- Reset values, all on the first clk edge with rst high:
  - tx_en 0, tx_data 0, busy 0, cmd_ready 1, fifo_level 0.
  - FIFO emptied, running checksum 0, FSM in IDLE.
- Reset mid-packet: the in-flight and queued commands are discarded and no further tx_en is issued.
- Push into an empty FIFO with the FSM in IDLE at edge k: tx_en is high during the cycle after edge k+1, with the first byte on tx_data.
- Byte-to-byte: tx_done high at edge j causes tx_en high in the cycle after edge j. No extra gap between bytes.
- Packet-to-packet: the last tx_done returns the FSM to IDLE, and the next queued command's first tx_en follows one edge later. This is one idle cycle.
- fifo_level changes:
  - +1 on a push-only edge.
  - −1 on a pop-only edge.
  - Unchanged on a simultaneous push and pop (possible only when the FIFO is not full).
- FIFO read/write pointers wrap modulo FIFO_DEPTH.
- busy rises on the pop edge and falls on the edge that returns the FSM to IDLE.

## Test plan
- CMD_PKT_LEN=16, CHECKSUM_EN=0. Write 16'h8A5C, tx_done returned 4 cycles after each strobe -> tx_data 8'h8A then 8'h5C, two tx_en pulses, busy low after the second tx_done.
- Read 16'h1234 -> a single byte 8'h12, one tx_en, then IDLE. With CHECKSUM_EN=1 -> 8'h12 then checksum 8'h12.
- CHECKSUM_EN=1, write 16'h8A5C -> 8'h8A, 8'h5C, 8'hE6. Write 16'hFFFF -> 8'hFF, 8'hFF, 8'hFE (wrap).
- CMD_PKT_LEN=24, write 24'h812233 -> 8'h81, 8'h22, 8'h33 in order.
- Backpressure: hold tx_done low, push 5 commands with FIFO_DEPTH=4. Required:
  - The first command pops.
  - Four more are accepted; fifo_level = 4, cmd_ready = 0.
  - Release tx_done: all five packets go out in push order, with fifo_level decrementing at each pop.
- Assert rst while in WAIT with 2 commands queued:
  - The next edge gives tx_en 0, fifo_level 0, busy 0.
  - A later tx_done pulse produces no tx_en.
  - A new push is then transmitted normally.
